// File: rtl/scanchain_rw_if.sv
// Command/response bus between the host bridge and scanchain_rw_controller.
//   cmd_*  : command channel, valid/ready. The controller drives cmd_ready.
//   resp_* : captured-data channel, valid/ready. The controller drives
//            resp_valid and resp_payload.
// The master modport is the host side and the slave modport is the controller.
interface scanchain_rw_if #(
    parameter int ADDR_BITS    = 12,
    parameter int PAYLOAD_BITS = 169,
    parameter int LEN_BITS     = $clog2(PAYLOAD_BITS + 1)
);
    logic                    cmd_ready;
    logic                    cmd_valid;
    logic                    cmd_reset;
    logic                    cmd_capture;
    logic [ADDR_BITS-1:0]    cmd_addr;
    logic [LEN_BITS-1:0]     cmd_len;
    logic [PAYLOAD_BITS-1:0] cmd_payload;
    logic                    resp_valid;
    logic                    resp_ready;
    logic [PAYLOAD_BITS-1:0] resp_payload;

    modport master (
        input  cmd_ready,
        output cmd_valid, cmd_reset, cmd_capture, cmd_addr, cmd_len, cmd_payload,
        input  resp_valid, resp_payload,
        output resp_ready
    );

    modport slave (
        output cmd_ready,
        input  cmd_valid, cmd_reset, cmd_capture, cmd_addr, cmd_len, cmd_payload,
        output resp_valid, resp_payload,
        input  resp_ready
    );
endinterface

// File: rtl/scanchain_rw_controller.sv
// Scan chain read/write controller.
// Takes commands from the host bus and either pulses the chain reset or
// shifts one frame (address MSB-first, then L payload bits MSB-first) into
// the chain. It can optionally capture the old chain contents from scan_out
// and return them on the response channel.
// Ports:
//   clk, reset  : clock and asynchronous active-high reset
//   bus         : command/response bus (slave side)
//   busy        : high whenever the controller is not idle
//   scan_clk, scan_en, scan_in, scan_reset : chain drive (all registered)
//   scan_out    : chain tail, sampled while the captured payload is shifted
module scanchain_rw_controller #(
    parameter int ADDR_BITS           = 12,
    parameter int PAYLOAD_BITS        = 169,
    parameter int CLOCKS_PER_SCAN_CLK = 5,
    parameter int LEN_BITS            = $clog2(PAYLOAD_BITS + 1),
    parameter int RESET_CYCLES        = 16
) (
    input  logic          clk,
    input  logic          reset,
    scanchain_rw_if.slave bus,
    output logic          busy,
    output logic          scan_clk,
    output logic          scan_en,
    output logic          scan_in,
    output logic          scan_reset,
    input  logic          scan_out
);
    localparam int FRAME_W = ADDR_BITS + PAYLOAD_BITS;
    // One counter serves as both the frame bit index and the reset-hold count.
    localparam int CNT_MAX = (FRAME_W > RESET_CYCLES) ? FRAME_W : RESET_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int PH_W    = (CLOCKS_PER_SCAN_CLK > 1) ? $clog2(CLOCKS_PER_SCAN_CLK) : 1;

    localparam logic [PH_W-1:0]     PH_LAST  = PH_W'(CLOCKS_PER_SCAN_CLK - 1);
    localparam logic [CNT_W-1:0]    RST_LAST = CNT_W'(RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0]    ADDR_CNT = CNT_W'(ADDR_BITS);
    localparam logic [CNT_W-1:0]    ADDR_M1  = CNT_W'(ADDR_BITS - 1);
    localparam logic [LEN_BITS-1:0] LEN_MAX  = LEN_BITS'(PAYLOAD_BITS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RST,
        S_SHIFT,
        S_RESP
    } state_t;

    state_t                  state_q, state_d;
    logic [PH_W-1:0]         phase_q, phase_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [CNT_W-1:0]        last_q, last_d;
    logic [FRAME_W-1:0]      frame_q, frame_d;
    logic [PAYLOAD_BITS-1:0] cap_q, cap_d;
    logic                    capture_q, capture_d;
    logic                    sclk_q, sclk_d;
    logic                    sen_q, sen_d;
    logic                    sin_q, sin_d;
    logic                    srst_q, srst_d;

    logic                    accept;
    logic [LEN_BITS-1:0]     len_eff;
    logic [PAYLOAD_BITS-1:0] pay_al;
    logic [FRAME_W-1:0]      frame_new;

    // A zero or oversized length selects the full payload width.
    function automatic logic [LEN_BITS-1:0] sat_len(input logic [LEN_BITS-1:0] len);
        if (len == '0 || len > LEN_MAX) begin
            return LEN_MAX;
        end
        return len;
    endfunction

    assign bus.cmd_ready    = (state_q == S_IDLE) && !bus.resp_valid && !reset;
    assign bus.resp_valid   = (state_q == S_RESP);
    assign bus.resp_payload = cap_q;
    assign busy             = (state_q != S_IDLE);
    assign scan_clk         = sclk_q;
    assign scan_en          = sen_q;
    assign scan_in          = sin_q;
    assign scan_reset       = srst_q;

    assign accept  = bus.cmd_valid && bus.cmd_ready;
    assign len_eff = sat_len(bus.cmd_len);
    // Left-align the used payload bits under the address so the whole frame
    // leaves from the MSB of one shift register.
    assign pay_al    = bus.cmd_payload << (LEN_MAX - len_eff);
    assign frame_new = {bus.cmd_addr, pay_al};

    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        cnt_d     = cnt_q;
        last_d    = last_q;
        frame_d   = frame_q;
        cap_d     = cap_q;
        capture_d = capture_q;
        sclk_d    = sclk_q;
        sen_d     = sen_q;
        sin_d     = sin_q;
        srst_d    = srst_q;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    cnt_d   = '0;
                    phase_d = '0;
                    cap_d   = '0;
                    sclk_d  = 1'b0;
                    sen_d   = 1'b1;
                    if (bus.cmd_reset) begin
                        state_d = S_RST;
                        srst_d  = 1'b1;
                        sin_d   = 1'b0;
                    end else begin
                        state_d   = S_SHIFT;
                        frame_d   = frame_new;
                        sin_d     = frame_new[FRAME_W-1];
                        last_d    = ADDR_M1 + CNT_W'(len_eff);
                        capture_d = bus.cmd_capture;
                    end
                end
            end

            S_RST: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == RST_LAST) begin
                    srst_d  = 1'b0;
                    sen_d   = 1'b0;
                    state_d = S_IDLE;
                end
            end

            S_SHIFT: begin
                if (phase_q == PH_LAST) begin
                    phase_d = '0;
                    if (!sclk_q) begin
                        // Rising scan_clk edge: the chain tail is valid now.
                        sclk_d = 1'b1;
                        if (capture_q && cnt_q >= ADDR_CNT) begin
                            cap_d = (cap_q << 1) | PAYLOAD_BITS'(scan_out);
                        end
                    end else if (cnt_q == last_q) begin
                        // Dropping scan_en makes the chain latch the new frame.
                        sclk_d  = 1'b0;
                        sen_d   = 1'b0;
                        sin_d   = 1'b0;
                        state_d = capture_q ? S_RESP : S_IDLE;
                    end else begin
                        sclk_d  = 1'b0;
                        cnt_d   = cnt_q + 1'b1;
                        frame_d = frame_q << 1;
                        sin_d   = frame_q[FRAME_W-2];
                    end
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end

            S_RESP: begin
                if (bus.resp_ready) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            phase_q   <= '0;
            cnt_q     <= '0;
            cap_q     <= '0;
            capture_q <= 1'b0;
            sclk_q    <= 1'b0;
            sen_q     <= 1'b0;
            sin_q     <= 1'b0;
            srst_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            cnt_q     <= cnt_d;
            cap_q     <= cap_d;
            capture_q <= capture_d;
            sclk_q    <= sclk_d;
            sen_q     <= sen_d;
            sin_q     <= sin_d;
            srst_q    <= srst_d;
        end
    end

    // Frame data and its end index are only meaningful while shifting.
    always_ff @(posedge clk) begin
        frame_q <= frame_d;
        last_q  <= last_d;
    end
endmodule
